// File: rtl/interboard_receiver.sv
// Receive half of the inter-board link: synchronizes the peer Request line,
// runs the 4-phase Request/Ack handshake, reassembles four 6-bit words into
// one 24-bit game message and presents it as a one-cycle en/rst pulse with
// held field outputs.
module interboard_receiver #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter int unsigned SYNC_STAGES    = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       Request,
   input  logic [5:0] interboard_data,
   output logic       Ack,
   output logic       interboard_rst,
   output logic       interboard_en,
   output logic [3:0] interboard_msg_type,
   output logic       interboard_move_dir,
   output logic [4:0] interboard_block_x,
   output logic [2:0] interboard_block_y,
   output logic [5:0] interboard_card,
   output logic [2:0] interboard_sel_len,
   output logic       busy
);

   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      ACK_HIGH,
      DELIVER
   } state_t;

   state_t                 state, state_next;
   logic [SYNC_STAGES-1:0] sync;
   logic                   req_s;
   logic [2:0]             word_cnt, word_cnt_next;
   logic [TMO_W-1:0]       tmo_cnt, tmo_cnt_next;
   logic [22:0]            shreg, shreg_next;
   logic                   ack_next, en_next, rst_next, load;

   // Request synchronizer chain.
   always_ff @(posedge clk) begin
      if (rst) sync <= '0;
      else     sync <= {sync[SYNC_STAGES-2:0], Request};
   end

   assign req_s = sync[SYNC_STAGES-1];

   // Next-state, word assembly and timeout logic.
   always_comb begin
      state_next    = state;
      word_cnt_next = word_cnt;
      shreg_next    = shreg;
      tmo_cnt_next  = '0;
      en_next       = 1'b0;
      rst_next      = 1'b0;
      load          = 1'b0;
      case (state)
         IDLE: begin
            if (req_s) begin
               // The spare bit is dropped as word0 passes position 16, so the
               // 23-bit register ends up holding {rst_flag, msg_type, words1-3}.
               shreg_next = {shreg[17], shreg[15:0], interboard_data};
               state_next = ACK_HIGH;
            end else if (word_cnt != 3'd0) begin
               if (tmo_cnt == TMO_LAST) word_cnt_next = '0;
               else                     tmo_cnt_next  = tmo_cnt + TMO_W'(1);
            end
         end
         ACK_HIGH: begin
            if (!req_s) begin
               word_cnt_next = word_cnt + 3'd1;
               state_next    = (word_cnt == 3'd3) ? DELIVER : IDLE;
            end else if (tmo_cnt == TMO_LAST) begin
               word_cnt_next = '0;
               state_next    = IDLE;
            end else begin
               tmo_cnt_next = tmo_cnt + TMO_W'(1);
            end
         end
         DELIVER: begin
            load          = 1'b1;
            rst_next      = shreg[22];
            en_next       = ~shreg[22];
            word_cnt_next = '0;
            state_next    = IDLE;
         end
         default: state_next = IDLE;
      endcase
      ack_next = (state_next == ACK_HIGH);
   end

   // State, counters, shift register and handshake/pulse registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         word_cnt       <= '0;
         tmo_cnt        <= '0;
         shreg          <= '0;
         Ack            <= 1'b0;
         interboard_en  <= 1'b0;
         interboard_rst <= 1'b0;
      end else begin
         state          <= state_next;
         word_cnt       <= word_cnt_next;
         tmo_cnt        <= tmo_cnt_next;
         shreg          <= shreg_next;
         Ack            <= ack_next;
         interboard_en  <= en_next;
         interboard_rst <= rst_next;
      end
   end

   // Decoded fields, held until the next delivered message.
   always_ff @(posedge clk) begin
      if (rst) begin
         interboard_msg_type <= '0;
         interboard_move_dir <= 1'b0;
         interboard_block_x  <= '0;
         interboard_block_y  <= '0;
         interboard_card     <= '0;
         interboard_sel_len  <= '0;
      end else if (load) begin
         interboard_msg_type <= shreg[21:18];
         interboard_move_dir <= shreg[17];
         interboard_block_x  <= shreg[16:12];
         interboard_block_y  <= shreg[11:9];
         interboard_card     <= shreg[8:3];
         interboard_sel_len  <= shreg[2:0];
      end
   end

   assign busy = (word_cnt != 3'd0) || Ack;

endmodule

// File: tb/tb_interboard_receiver.sv
// Directed self-checking bench for interboard_receiver acting as the peer
// transmitter on the Request/Ack handshake.
module tb_interboard_receiver;

   logic       clk = 1'b0;
   logic       rst;
   logic       Request;
   logic [5:0] interboard_data;
   logic       Ack;
   logic       interboard_rst;
   logic       interboard_en;
   logic [3:0] interboard_msg_type;
   logic       interboard_move_dir;
   logic [4:0] interboard_block_x;
   logic [2:0] interboard_block_y;
   logic [5:0] interboard_card;
   logic [2:0] interboard_sel_len;
   logic       busy;

   int checks   = 0;
   int failures = 0;
   int en_count  = 0;
   int rst_count = 0;
   logic [5:0] cap_card [0:15];

   always #5 clk = ~clk;

   interboard_receiver #(
      .TIMEOUT_CYCLES(50),
      .SYNC_STAGES   (2)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .Request            (Request),
      .interboard_data    (interboard_data),
      .Ack                (Ack),
      .interboard_rst     (interboard_rst),
      .interboard_en      (interboard_en),
      .interboard_msg_type(interboard_msg_type),
      .interboard_move_dir(interboard_move_dir),
      .interboard_block_x (interboard_block_x),
      .interboard_block_y (interboard_block_y),
      .interboard_card    (interboard_card),
      .interboard_sel_len (interboard_sel_len),
      .busy               (busy)
   );

   // Pulse monitor: counts en/rst pulses and records the card of each en.
   always @(negedge clk) begin
      if (interboard_en) begin
         cap_card[en_count % 16] <= interboard_card;
         en_count <= en_count + 1;
      end
      if (interboard_rst) rst_count <= rst_count + 1;
   end

   task automatic wait_ack(input logic level, input string name);
      int n;
      n = 0;
      while (Ack !== level && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (Ack !== level) begin
         failures++;
         $display("FAIL %s: Ack=%b required %b within 200 cycles", name, Ack, level);
      end
   endtask

   task automatic send_word(input logic [5:0] w);
      interboard_data = w;
      Request = 1'b1;
      wait_ack(1'b1, "ack_rise");
      Request = 1'b0;
      wait_ack(1'b0, "ack_fall");
   endtask

   task automatic send_msg(input logic [5:0] w0, input logic [5:0] w1,
                           input logic [5:0] w2, input logic [5:0] w3);
      send_word(w0);
      send_word(w1);
      send_word(w2);
      send_word(w3);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      Request = 1'b0;
      interboard_data = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({Ack, interboard_en, interboard_rst, busy} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_ctrl: ack/en/rst/busy=%b required 0000",
                  {Ack, interboard_en, interboard_rst, busy});
      end
      checks++;
      if ({interboard_msg_type, interboard_move_dir, interboard_block_x,
           interboard_block_y, interboard_card, interboard_sel_len} !== 22'd0) begin
         failures++;
         $display("FAIL reset_fields: got %h required 0",
                  {interboard_msg_type, interboard_move_dir, interboard_block_x,
                   interboard_block_y, interboard_card, interboard_sel_len});
      end
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_single;
      int e0, r0;
      e0 = en_count;
      r0 = rst_count;
      send_msg(6'h05, 6'h31, 6'h35, 6'h13);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (en_count !== e0 + 1) begin
         failures++;
         $display("FAIL single_en_count: got %0d required %0d", en_count - e0, 1);
      end
      checks++;
      if (rst_count !== r0) begin
         failures++;
         $display("FAIL single_rst_count: got %0d required 0", rst_count - r0);
      end
      checks++;
      if ({interboard_msg_type, interboard_move_dir, interboard_block_x,
           interboard_block_y, interboard_card, interboard_sel_len}
          !== {4'd5, 1'b1, 5'd17, 3'd6, 6'd42, 3'd3}) begin
         failures++;
         $display("FAIL single_fields: type=%0d dir=%0d x=%0d y=%0d card=%0d sel=%0d required 5 1 17 6 42 3",
                  interboard_msg_type, interboard_move_dir, interboard_block_x,
                  interboard_block_y, interboard_card, interboard_sel_len);
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL single_busy: got %b required 0", busy);
      end
   endtask

   task automatic test_rst_msg;
      int e0, r0;
      e0 = en_count;
      r0 = rst_count;
      send_msg(6'h20, 6'h00, 6'h00, 6'h00);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (rst_count !== r0 + 1) begin
         failures++;
         $display("FAIL rstmsg_rst_count: got %0d required 1", rst_count - r0);
      end
      checks++;
      if (en_count !== e0) begin
         failures++;
         $display("FAIL rstmsg_en_count: got %0d required 0", en_count - e0);
      end
      checks++;
      if ({interboard_msg_type, interboard_block_x, interboard_card} !== 15'd0) begin
         failures++;
         $display("FAIL rstmsg_fields: type=%0d x=%0d card=%0d required 0 0 0",
                  interboard_msg_type, interboard_block_x, interboard_card);
      end
   endtask

   task automatic test_latency;
      int n;
      interboard_data = 6'h05;
      Request = 1'b1;
      n = 0;
      while (n < 20) begin
         @(posedge clk); #1;
         n++;
         if (Ack) break;
      end
      checks++;
      if (n !== 3) begin
         failures++;
         $display("FAIL latency_rise: got %0d cycles required 3", n);
      end
      Request = 1'b0;
      wait_ack(1'b0, "lat_w0_fall");
      send_word(6'h31);
      send_word(6'h35);
      interboard_data = 6'h13;
      Request = 1'b1;
      wait_ack(1'b1, "lat_w3_rise");
      Request = 1'b0;
      n = 0;
      while (n < 20) begin
         @(posedge clk); #1;
         n++;
         if (!Ack) break;
      end
      checks++;
      if (n !== 3) begin
         failures++;
         $display("FAIL latency_fall: got %0d cycles required 3", n);
      end
      checks++;
      if (interboard_en !== 1'b0) begin
         failures++;
         $display("FAIL latency_en_early: got %b required 0", interboard_en);
      end
      @(posedge clk); #1;
      checks++;
      if (interboard_en !== 1'b1) begin
         failures++;
         $display("FAIL latency_en_pulse: got %b required 1", interboard_en);
      end
      @(posedge clk); #1;
      checks++;
      if (interboard_en !== 1'b0) begin
         failures++;
         $display("FAIL latency_en_width: got %b required 0", interboard_en);
      end
   endtask

   task automatic test_timeout;
      int e0;
      e0 = en_count;
      send_word(6'h05);
      send_word(6'h31);
      repeat (60) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || en_count !== e0) begin
         failures++;
         $display("FAIL timeout_stall: busy=%b pulses=%0d required 0 0", busy, en_count - e0);
      end
      send_msg(6'h05, 6'h31, 6'h35, 6'h13);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (en_count !== e0 + 1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL timeout_after: pulses=%0d busy=%b required 1 0", en_count - e0, busy);
      end
      checks++;
      if ({interboard_msg_type, interboard_move_dir, interboard_block_x,
           interboard_block_y, interboard_card, interboard_sel_len}
          !== {4'd5, 1'b1, 5'd17, 3'd6, 6'd42, 3'd3}) begin
         failures++;
         $display("FAIL timeout_fields: type=%0d dir=%0d x=%0d y=%0d card=%0d sel=%0d required 5 1 17 6 42 3",
                  interboard_msg_type, interboard_move_dir, interboard_block_x,
                  interboard_block_y, interboard_card, interboard_sel_len);
      end
   endtask

   task automatic test_reset_mid;
      int e0;
      send_word(6'h07);
      send_word(6'h22);
      send_word(6'h10);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if ({Ack, busy, interboard_en, interboard_rst} !== 4'b0000) begin
         failures++;
         $display("FAIL midrst_ctrl: ack/busy/en/rst=%b required 0000",
                  {Ack, busy, interboard_en, interboard_rst});
      end
      checks++;
      if ({interboard_msg_type, interboard_move_dir, interboard_block_x,
           interboard_block_y, interboard_card, interboard_sel_len} !== 22'd0) begin
         failures++;
         $display("FAIL midrst_fields: got %h required 0",
                  {interboard_msg_type, interboard_move_dir, interboard_block_x,
                   interboard_block_y, interboard_card, interboard_sel_len});
      end
      repeat (2) @(posedge clk);
      #1;
      e0 = en_count;
      send_msg(6'h05, 6'h31, 6'h35, 6'h13);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (en_count !== e0 + 1 || busy !== 1'b0 || interboard_card !== 6'd42 ||
          interboard_block_x !== 5'd17) begin
         failures++;
         $display("FAIL midrst_after: pulses=%0d busy=%b card=%0d x=%0d required 1 0 42 17",
                  en_count - e0, busy, interboard_card, interboard_block_x);
      end
   endtask

   task automatic test_back_to_back;
      int e0;
      e0 = en_count;
      send_msg(6'h05, 6'h31, 6'h35, 6'h13);
      send_msg(6'h05, 6'h31, 6'h30, 6'h0B);
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (en_count !== e0 + 2) begin
         failures++;
         $display("FAIL b2b_en_count: got %0d required 2", en_count - e0);
      end
      checks++;
      if (cap_card[e0 % 16] !== 6'd42 || cap_card[(e0 + 1) % 16] !== 6'd1) begin
         failures++;
         $display("FAIL b2b_cards: got %0d %0d required 42 1",
                  cap_card[e0 % 16], cap_card[(e0 + 1) % 16]);
      end
      checks++;
      if ({interboard_msg_type, interboard_move_dir, interboard_block_x,
           interboard_block_y, interboard_card, interboard_sel_len}
          !== {4'd5, 1'b1, 5'd17, 3'd6, 6'd1, 3'd3}) begin
         failures++;
         $display("FAIL b2b_fields: type=%0d dir=%0d x=%0d y=%0d card=%0d sel=%0d required 5 1 17 6 1 3",
                  interboard_msg_type, interboard_move_dir, interboard_block_x,
                  interboard_block_y, interboard_card, interboard_sel_len);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset;
      test_single;
      test_rst_msg;
      test_latency;
      test_timeout;
      test_reset_mid;
      test_back_to_back;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
